// File: rtl/thumb_fetch.sv
// Thumb fetch stage: reads 32-bit words, presents 16-bit instructions over valid/ready.
// Optional FETCH_HALFWORD_REUSE_EN serves upper halfwords straight from the word buffer.
module thumb_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_mem_req,
  output logic [9:0]  o_mem_addr,
  input  logic [31:0] i_mem_rdata,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [15:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc
);

  typedef enum logic [1:0] {FETCH, WAIT, OUT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [15:0] r_inst;
  logic [31:0] r_inst_pc;
  logic [31:0] w_pc_inc;
  logic [15:0] w_buf_hi;
  logic        w_load_mem, w_load_buf, w_reuse;
  logic        w_unused;

  assign w_pc_inc     = r_fetch_pc + 32'd2;
  assign w_unused     = i_redirect_pc[0];
  assign o_mem_addr   = r_fetch_pc[11:2];
  assign o_inst_valid = (r_state == OUT);
  assign o_inst       = r_inst;
  assign o_inst_pc    = r_inst_pc;

`ifdef FETCH_HALFWORD_REUSE_EN
  logic [31:0] r_buf_word;
  logic        r_buf_valid;

  // An odd halfword pc means its word was the last one captured.
  assign w_reuse  = r_fetch_pc[1] & r_buf_valid;
  assign w_buf_hi = r_buf_word[31:16];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_buf_word  <= 32'h0;
      r_buf_valid <= 1'b0;
    end else if (i_redirect_valid) begin
      r_buf_valid <= 1'b0;
    end else if (w_load_mem) begin
      r_buf_word  <= i_mem_rdata;
      r_buf_valid <= 1'b1;
    end
  end
`else
  assign w_reuse  = 1'b0;
  assign w_buf_hi = 16'h0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= FETCH;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_mem_req   = 1'b0;
    w_load_mem  = 1'b0;
    w_load_buf  = 1'b0;
    if (i_redirect_valid) begin
      w_state_nxt = FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          o_mem_req   = 1'b1;
          w_state_nxt = WAIT;
        end
        WAIT: begin
          w_load_mem  = 1'b1;
          w_state_nxt = OUT;
        end
        OUT: begin
          if (i_inst_ready) begin
            if (w_reuse) begin
              w_load_buf = 1'b1;
            end else begin
              o_mem_req   = 1'b1;
              w_state_nxt = WAIT;
            end
          end
        end
        default: w_state_nxt = FETCH;
      endcase
    end
    // Reset must not leak a request from whatever state is still registered.
    if (i_reset) o_mem_req = 1'b0;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_fetch_pc <= {RESET_PC[31:1], 1'b0};
      r_inst     <= 16'h0;
      r_inst_pc  <= 32'h0;
    end else if (i_redirect_valid) begin
      r_fetch_pc <= {i_redirect_pc[31:1], 1'b0};
    end else if (w_load_mem) begin
      r_inst     <= r_fetch_pc[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
      r_inst_pc  <= r_fetch_pc;
      r_fetch_pc <= w_pc_inc;
    end else if (w_load_buf) begin
      r_inst     <= w_buf_hi;
      r_inst_pc  <= r_fetch_pc;
      r_fetch_pc <= w_pc_inc;
    end
  end

endmodule

// File: tb/tb_thumb_fetch.sv
// Bench for thumb_fetch: directed timing cases plus a randomized run checked
// against a stream model (expected pc sequence + halfword lookup in memory).
module tb_thumb_fetch;

`ifdef FETCH_HALFWORD_REUSE_EN
  localparam int REUSE = 1;
`else
  localparam int REUSE = 0;
`endif
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'h0000_0FFE;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, mem_req, inst_valid, inst_ready, redirect_valid;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata, inst_pc, redirect_pc;
  logic [15:0] inst;

  logic        w_reset, w_mem_req, w_inst_valid;
  logic [9:0]  w_mem_addr;
  logic [31:0] w_mem_rdata, w_inst_pc;
  logic [15:0] w_inst;

  logic [31:0] mem [1024];

  thumb_fetch #(.RESET_PC(RST_PC)) dut (
    .i_clock(clock), .i_reset(reset),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata),
    .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
    .o_inst(inst), .o_inst_pc(inst_pc),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc)
  );

  thumb_fetch #(.RESET_PC(WRAP_PC)) dut_wrap (
    .i_clock(clock), .i_reset(w_reset),
    .o_mem_req(w_mem_req), .o_mem_addr(w_mem_addr), .i_mem_rdata(w_mem_rdata),
    .o_inst_valid(w_inst_valid), .i_inst_ready(1'b1),
    .o_inst(w_inst), .o_inst_pc(w_inst_pc),
    .i_redirect_valid(1'b0), .i_redirect_pc(32'h0)
  );

  // Memory answers one cycle after a request; garbage otherwise.
  always @(posedge clock) mem_rdata   <= mem_req   ? mem[mem_addr]   : $urandom();
  always @(posedge clock) w_mem_rdata <= w_mem_req ? mem[w_mem_addr] : $urandom();

  int n_vec = 0, n_miss = 0, nreq0 = 0, hs_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] half_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[11:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  // Stream model: the decoder must see exp_pc, exp_pc+2, ... until a redirect or reset.
  initial begin
    logic [31:0] exp_pc;
    logic        p_req, p_valid, p_ready, p_redir, p_rst;
    logic [15:0] p_inst;
    logic [31:0] p_pc;
    exp_pc = RST_PC; p_rst = 1'b1; p_req = 1'b0; p_valid = 1'b0;
    p_ready = 1'b0; p_redir = 1'b0; p_inst = 16'h0; p_pc = 32'h0;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("rst_req", mem_req, 0);
        exp_pc = RST_PC;
      end else begin
        if (!p_rst) begin
          chk("b2b_req", mem_req & p_req, 0);
          if (p_valid && !p_ready && !p_redir) begin
            chk("hold_valid", inst_valid, 1);
            chk("hold_inst", inst, p_inst);
            chk("hold_pc", inst_pc, p_pc);
          end
          if (p_redir && !redirect_valid) chk("redir_lat", mem_req, 1);
        end
        if (inst_valid && inst_ready) begin
          chk("hs_pc", inst_pc, exp_pc);
          chk("hs_inst", inst, half_at(exp_pc));
          exp_pc = exp_pc + 32'd2;
          hs_cnt++;
        end
        if (mem_req) begin
          chk("req_addr", mem_addr, exp_pc[11:2]);
          chk("req_redir", redirect_valid, 0);
        end
        if (redirect_valid) exp_pc = {redirect_pc[31:1], 1'b0};
      end
      p_req = mem_req; p_valid = inst_valid; p_ready = inst_ready;
      p_redir = redirect_valid; p_rst = reset; p_inst = inst; p_pc = inst_pc;
    end
  end

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (mem_req && mem_addr == 10'd0) nreq0++;
    end while (!inst_valid && n < lim);
    if (!inst_valid) chk("valid_timeout", inst_valid, 1);
  endtask

  // Leaves the caller just after the edge that starts the first post-reset cycle.
  task automatic do_reset(input logic rdy);
    @(posedge clock); #1;
    reset = 1'b1; redirect_valid = 1'b0; inst_ready = rdy;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] w;
    reset = 1'b1; w_reset = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom();
    mem[0] = 32'h3001_2002;

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, RST_PC[11:2]);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("wrap_rst_addr", w_mem_addr, 10'h3FF);

    // Reset vector and first-instruction latency
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, 0);
    nreq0 = 1;
    wait_valid(6, n);
    chk("first_lat", n, 2);
    chk("first_inst", inst, 16'h2002);
    chk("first_pc", inst_pc, 0);
    wait_valid(6, n);
    chk("second_lat", n, REUSE ? 1 : 2);
    chk("second_inst", inst, 16'h3001);
    chk("second_pc", inst_pc, 2);
    chk("word0_reqs", nreq0, REUSE ? 1 : 2);

    // Backpressure
    do_reset(1'b0);
    @(negedge clock);
    wait_valid(6, n);
    chk("bp_inst0", inst, 16'h2002);
    repeat (5) begin
      @(negedge clock);
      chk("bp_valid", inst_valid, 1);
      chk("bp_inst", inst, 16'h2002);
      chk("bp_pc", inst_pc, 0);
      chk("bp_req", mem_req, 0);
    end
    @(posedge clock); #1 inst_ready = 1'b1;
    @(negedge clock);
    chk("bp_hs_inst", inst, 16'h2002);
    wait_valid(6, n);
    chk("bp_next_inst", inst, 16'h3001);
    chk("bp_next_pc", inst_pc, 2);

    // Mid-operation reset while presenting
    do_reset(1'b0);
    @(negedge clock);
    wait_valid(6, n);
    chk("mr_pre_valid", inst_valid, 1);
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    chk("mr_req_in_rst", mem_req, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("mr_valid", inst_valid, 0);
    chk("mr_inst", inst, 0);
    chk("mr_pc", inst_pc, 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("mr_restart_req", mem_req, 1);
    chk("mr_restart_addr", mem_addr, RST_PC[11:2]);

    // Redirect while waiting on memory
    do_reset(1'b1);
    @(negedge clock);
    @(posedge clock); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0013; inst_ready = 1'b0;
    @(negedge clock);
    chk("rd_noreq", mem_req, 0);
    @(posedge clock); #1 redirect_valid = 1'b0;
    @(negedge clock);
    chk("rd_req", mem_req, 1);
    chk("rd_addr", mem_addr, 10'h004);
    wait_valid(6, n);
    w = mem[4];
    chk("rd_lat", n, 2);
    chk("rd_pc", inst_pc, 32'h12);
    chk("rd_inst", inst, w[31:16]);

    // Redirect together with a handshake
    @(posedge clock); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040; inst_ready = 1'b1;
    @(negedge clock);
    chk("rh_valid", inst_valid, 1);
    chk("rh_noreq", mem_req, 0);
    @(posedge clock); #1 redirect_valid = 1'b0;
    @(negedge clock);
    chk("rh_req", mem_req, 1);
    chk("rh_addr", mem_addr, 10'h010);
    wait_valid(6, n);
    w = mem[16];
    chk("rh_pc", inst_pc, 32'h40);
    chk("rh_inst", inst, w[15:0]);

    // Wrap-around on the second instance
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    mem[1023] = 32'hDF64_0000;
    mem[0]    = 32'h0000_2001;
    @(posedge clock); #1 w_reset = 1'b0;
    @(negedge clock);
    chk("wr_req", w_mem_req, 1);
    chk("wr_addr", w_mem_addr, 10'h3FF);
    @(negedge clock);
    chk("wr_wait_valid", w_inst_valid, 0);
    @(negedge clock);
    chk("wr_valid0", w_inst_valid, 1);
    chk("wr_pc0", w_inst_pc, 32'h0000_0FFE);
    chk("wr_inst0", w_inst, 16'hDF64);
    chk("wr_req1", w_mem_req, 1);
    chk("wr_addr1", w_mem_addr, 10'h000);
    repeat (2) @(negedge clock);
    chk("wr_valid1", w_inst_valid, 1);
    chk("wr_pc1", w_inst_pc, 32'h0000_1000);
    chk("wr_inst1", w_inst, 16'h2001);
    @(posedge clock); #1 w_reset = 1'b1;

    // Randomized traffic against the stream model
    hs_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #1;
      reset          = ($urandom_range(0, 299) == 0);
      inst_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'h0000_0FFC + 32'($urandom_range(0, 3)))
                                                   : $urandom();
    end
    @(posedge clock); #1;
    reset = 1'b0; redirect_valid = 1'b0;
    @(negedge clock);
    chk("rand_progress", hs_cnt > 200, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/thumb_fetch.md
# thumb_fetch

- Instruction fetch stage for the Thumb-subset core; sits directly upstream of the instruction decoder.
- Reads 32-bit words from the 1024-word instruction memory, extracts 16-bit instructions little-endian, and presents one instruction plus its address per valid/ready handshake.
- Accepts a branch redirect from the execute side that flushes all fetch state.

## Interface
- RESET_PC, 32'h0000_0000, byte address of the first instruction after reset; bit 0 ignored.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_req  out  1  word read request this cycle.
- mem_addr  out  10  word address, equal to fetch_pc[11:2].
- mem_rdata  in  32  read data, valid exactly one cycle after mem_req.
- inst_valid  out  1  inst and inst_pc hold a valid instruction.
- inst_ready  in  1  decoder accepts the instruction this cycle.
- inst  out  16  instruction halfword.
- inst_pc  out  32  byte address of inst. Decoder adds 4 for architectural PC reads.
- redirect_valid  in  1  branch taken; refetch from redirect_pc.
- redirect_pc  in  32  branch target byte address; bit 0 ignored.

## Operation
- Internal state:
  - fetch_pc: 32-bit; bit 0 always 0.
  - buf_word: 32-bit.
  - buf_valid.
  - FSM with states FETCH, WAIT, OUT.
- Halfword select:
  - pc[1]=0 -> word[15:0].
  - pc[1]=1 -> word[31:16].
- FETCH:
  - mem_req=1, mem_addr=fetch_pc[11:2].
  - Next state: WAIT.
- WAIT:
  - Capture mem_rdata into buf_word; set buf_valid.
  - Load the selected halfword into inst; set inst_pc=fetch_pc.
  - fetch_pc += 2.
  - Next state: OUT.
- OUT:
  - inst_valid=1.
  - inst_ready=0: hold inst and inst_pc stable; no memory request.
  - inst_ready=1 and the next halfword is in the buffer (reuse feature enabled): load it from buf_word, fetch_pc += 2, stay in OUT.
  - inst_ready=1 otherwise: assert mem_req with mem_addr=fetch_pc[11:2] in the same cycle, go to WAIT, inst_valid=0 next cycle.
- "Next halfword is in the buffer" means fetch_pc[1]=1 and buf_valid=1.
- Redirect has highest priority, in any state:
  - Next cycle: state FETCH, fetch_pc=redirect_pc with bit 0 cleared, buf_valid=0, inst_valid=0.
  - Any in-flight mem_rdata is discarded.
  - mem_req is not asserted in the redirect cycle.
- redirect_valid and inst_ready high together: the current instruction counts as consumed by the decoder; fetch still flushes.
- Wrap-around:
  - fetch_pc increments modulo 2^32.
  - mem_addr wraps modulo 1024 words (4 KiB).
  - inst_pc reports the full 32-bit fetch_pc.
- At most one memory request is ever outstanding.

## Timing
- Reset values:
  - mem_req=0, mem_addr=RESET_PC[11:2], inst_valid=0, inst=0, inst_pc=0.
  - fetch_pc=RESET_PC & ~1, buf_valid=0, state FETCH.
- First cycle after reset deasserts: mem_req=1.
- First instruction: inst_valid=1 two cycles after the first mem_req (request cycle, data cycle, output cycle).
- Sustained throughput with inst_ready held high:
  - Word-aligned instructions: 1 instruction per 2 cycles.
  - With reuse, the upper halfword follows its lower halfword back-to-back.
- Redirect latency:
  - Redirect at cycle N -> mem_req for the target at N+1.
  - Target instruction valid at N+3.
- Reset asserted mid-operation:
  - All state returns to reset values at the next edge.
  - A response arriving after reset is ignored.
- inst and inst_pc change only on a handshake, a WAIT completion, a redirect, or a reset.

## Configuration
- Macro: FETCH_HALFWORD_REUSE_EN.
- Defined:
  - An upper halfword whose word is already in buf_word is served from the buffer without a memory read.
  - Costs 1 cycle per such instruction.
- Undefined:
  - buf_word is never reused; every instruction issues its own mem_req through WAIT.
  - Throughput is 1 instruction per 2 cycles regardless of alignment.
- Instruction and address sequences are identical either way; only mem_req count and timing differ.

## Test plan
- Reset vector:
  - Setup: RESET_PC=0, mem[0]=32'h3001_2002, inst_ready=1.
  - Expect: inst=16'h2002 at inst_pc=0, then inst=16'h3001 at inst_pc=2.
  - With FETCH_HALFWORD_REUSE_EN: exactly one mem_req for word 0.
  - Without FETCH_HALFWORD_REUSE_EN: two mem_reqs for word 0.
- Backpressure:
  - Stimulus: hold inst_ready=0 for 5 cycles on inst=16'h2002.
  - Expect: inst and inst_pc stable; mem_req=0 throughout; the next instruction appears only after inst_ready rises.
- Redirect:
  - Stimulus: redirect_valid=1, redirect_pc=32'h0000_0013 while in WAIT.
  - Expect: stale rdata dropped; next mem_addr=10'h004; first output inst_pc=32'h12, inst=mem[4][31:16].
- Wrap:
  - Setup: RESET_PC=32'h0000_0FFE, mem[1023]=32'hDF64_0000, mem[0]=32'h0000_2001.
  - Expect: inst_pc=FFE with inst=DF64, then inst_pc=32'h1000, mem_addr=0, inst=2001.
- Mid-operation reset:
  - Stimulus: assert reset during OUT with inst_valid=1.
  - Expect: inst_valid=0 the next cycle; fetch restarts at RESET_PC with mem_req one cycle after reset deasserts.
- Redirect plus handshake:
  - Stimulus: redirect_valid=1 and inst_ready=1 in the same cycle.
  - Expect: no further instruction from the old stream is ever presented.
